// File: rtl/sio_uart.sv
// 8N1 serial port on the I/O bus: independent receiver and transmitter,
// four byte registers, level interrupts for receive-ready and transmit-ready.
module sio_uart #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 38400
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wt,
  input  logic       rxd,
  output logic       txd,
  output logic       irq_r,
  output logic       irq_t
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HLAST = CW'((DIV / 2 > 0) ? DIV / 2 - 1 : 0);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rst_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tst_e;

  logic       ack_q, fin, rd_fin, wr_fin, rd_go;
  logic [7:0] dout_q, dout_d, rmux;
  logic       irq_r_q, irq_t_q;

  logic          rs1_q, rs2_q, store;
  rst_e          rst_q, rst_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    rbit_q, rbit_d;
  logic [7:0]    rsh_q, rsh_d, rdat_q, rdat_d;
  logic          rrdy_q, rrdy_d, rovr_q, rovr_d, rie_q, rie_d;

  tst_e          tst_q, tst_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    tbit_q, tbit_d;
  logic [7:0]    tsh_q, tsh_d;
  logic          txd_q, txd_d, trdy_q, trdy_d, tie_q, tie_d;

  assign fin    = en & ack_q;
  assign rd_fin = fin & ~wr;
  assign wr_fin = fin & wr;
  assign rd_go  = en & ~ack_q & ~wr;

  assign wt       = ~ack_q;
  assign data_out = dout_q;
  assign txd      = txd_q;
  assign irq_r    = irq_r_q;
  assign irq_t    = irq_t_q;

  // Read data is latched on the edge that raises ack, so it is valid while wt=0
  always_comb begin
    rmux = 8'h00;
    unique case (addr)
      2'd0: rmux = {5'b0, rovr_q, rie_q, rrdy_q};
      2'd1: rmux = rdat_q;
      2'd2: rmux = {6'b0, tie_q, trdy_q};
      default: rmux = 8'h00;
    endcase
    dout_d = rd_go ? rmux : 8'h00;
  end

  always_comb begin
    rst_d  = rst_q;
    rcnt_d = rcnt_q + 1'b1;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    store  = 1'b0;
    unique case (rst_q)
      R_IDLE: begin
        rcnt_d = '0;
        if (!rs2_q) rst_d = R_START;
      end
      R_START: if (rcnt_q == HLAST) begin
        rcnt_d = '0;
        rbit_d = '0;
        rst_d  = rs2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rcnt_q == LAST) begin
        rcnt_d = '0;
        rsh_d  = {rs2_q, rsh_q[7:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == 3'd7) rst_d = R_STOP;
      end
      R_STOP: if (rcnt_q == LAST) begin
        rcnt_d = '0;
        store  = rs2_q;
        rst_d  = R_IDLE;
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    rrdy_d = rrdy_q;
    rovr_d = rovr_q;
    rie_d  = rie_q;
    rdat_d = rdat_q;
    if (wr_fin && addr == 2'd0) begin
      rie_d  = data_in[1];
      rovr_d = 1'b0;
    end
    if (rd_fin && addr == 2'd1) begin
      rrdy_d = 1'b0;
      rovr_d = 1'b0;
    end
    // A new byte beats a simultaneous data read
    if (store) begin
      rdat_d = rsh_q;
      rrdy_d = 1'b1;
      rovr_d = (rd_fin && addr == 2'd1) ? rovr_q : (rovr_d | rrdy_q);
    end
  end

  always_comb begin
    tst_d  = tst_q;
    tcnt_d = tcnt_q + 1'b1;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    txd_d  = txd_q;
    trdy_d = trdy_q;
    tie_d  = tie_q;
    if (wr_fin && addr == 2'd2) tie_d = data_in[1];
    unique case (tst_q)
      T_IDLE: begin
        tcnt_d = '0;
        if (wr_fin && addr == 2'd3 && trdy_q) begin
          tsh_d  = data_in;
          trdy_d = 1'b0;
          txd_d  = 1'b0;
          tst_d  = T_START;
        end
      end
      T_START: if (tcnt_q == LAST) begin
        tcnt_d = '0;
        tbit_d = '0;
        txd_d  = tsh_q[0];
        tsh_d  = {1'b0, tsh_q[7:1]};
        tst_d  = T_DATA;
      end
      T_DATA: if (tcnt_q == LAST) begin
        tcnt_d = '0;
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == 3'd7) begin
          txd_d = 1'b1;
          tst_d = T_STOP;
        end else begin
          txd_d = tsh_q[0];
          tsh_d = {1'b0, tsh_q[7:1]};
        end
      end
      T_STOP: if (tcnt_q == LAST) begin
        tcnt_d = '0;
        trdy_d = 1'b1;
        tst_d  = T_IDLE;
      end
      default: tst_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      dout_q  <= 8'h00;
      irq_r_q <= 1'b0;
      irq_t_q <= 1'b0;
      rs1_q   <= 1'b1;
      rs2_q   <= 1'b1;
      rst_q   <= R_IDLE;
      rcnt_q  <= '0;
      rbit_q  <= '0;
      rsh_q   <= 8'h00;
      rdat_q  <= 8'h00;
      rrdy_q  <= 1'b0;
      rovr_q  <= 1'b0;
      rie_q   <= 1'b0;
      tst_q   <= T_IDLE;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      tsh_q   <= 8'h00;
      txd_q   <= 1'b1;
      trdy_q  <= 1'b1;
      tie_q   <= 1'b0;
    end else begin
      ack_q   <= en & ~ack_q;
      dout_q  <= dout_d;
      irq_r_q <= rrdy_q & rie_q;
      irq_t_q <= trdy_q & tie_q;
      rs1_q   <= rxd;
      rs2_q   <= rs1_q;
      rst_q   <= rst_d;
      rcnt_q  <= rcnt_d;
      rbit_q  <= rbit_d;
      rsh_q   <= rsh_d;
      rdat_q  <= rdat_d;
      rrdy_q  <= rrdy_d;
      rovr_q  <= rovr_d;
      rie_q   <= rie_d;
      tst_q   <= tst_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      tsh_q   <= tsh_d;
      txd_q   <= txd_d;
      trdy_q  <= trdy_d;
      tie_q   <= tie_d;
    end
  end
endmodule
